digit_entry_display: RTL and testbench
======================================

Name: digit_entry_display

Overview:
Parametrised N-digit keypad-style entry display. Debounces enter/clear buttons and captures a 4-bit switch value into a shifting digit buffer on each enter press. Shift direction is selectable. Drives a multiplexed, active-low seven-segment display with per-digit blanking of unfilled digits. It sits at board top level between raw buttons/switches and the display pins. It generalises the fixed 4-digit rotating entry display with clear, direction and fill-count behaviour.

Parameters:
NUM_DIGITS, 4, number of display digits (2..8)
DB_CYCLES, 500000, consecutive stable cycles required before a debounced level changes
REFRESH_CYCLES, 100000, clk cycles each digit is lit per scan step

Ports:
clk  in  1  system clock, single domain
rst  in  1  asynchronous, active-low reset
enter  in  1  raw push button, active-high, capture dataIn
clear  in  1  raw push button, active-high, empty the buffer
dir  in  1  raw switch; 0 = new digit enters at digit 0 (shift left), 1 = new digit enters at digit NUM_DIGITS-1 (shift right)
dataIn  in  4  hex value to capture
sevenSeg  out  8  active-low segments {dp,g,f,e,d,c,b,a}
anode  out  NUM_DIGITS  active-low one-hot digit select
dataLed  out  4  last captured value
count  out  $clog2(NUM_DIGITS+1)  number of filled digits, saturating

Behaviour:
- Reset (rst=0, async) forces the following immediately:
  - dig[*]=0, vld[*]=0, count=0, dataLed=0
  - scan index=0, refresh counter=0
  - anode all 1, sevenSeg=8'hFF
  - debounced levels 0, sync flops 0
- Button conditioning for enter and clear:
  - 2-FF synchroniser, then debounce counter.
  - The counter resets whenever the synced input equals the current debounced level.
  - The debounced level toggles once the input has differed for DB_CYCLES consecutive cycles.
  - A rising edge of the debounced level produces a 1-cycle pulse.
  - Latency from a clean raw edge to the pulse is 2+DB_CYCLES+1 cycles.
  - Release generates no pulse.
- dir: 2-FF synchronised only, no debounce; sampled in the cycle of the enter pulse.
- Enter pulse, dir=0:
  - dig[i]<=dig[i-1] and vld[i]<=vld[i-1] for i>0
  - dig[0]<=dataIn, vld[0]<=1
- Enter pulse, dir=1: mirror image of dir=0, with new data entering at index NUM_DIGITS-1.
- On every enter pulse:
  - dataLed<=dataIn
  - count<=min(count+1, NUM_DIGITS)
- Full buffer + enter: the digit shifted out is discarded (oldest lost); count stays at NUM_DIGITS.
- Clear pulse: dig=0, vld=0, count=0, dataLed=0. When clear and enter pulse in the same cycle, clear wins and nothing is captured.
- Direction change with a partially filled buffer: no re-alignment; existing vld pattern shifts as-is.
- Scan:
  - Refresh counter counts 0..REFRESH_CYCLES-1 and wraps.
  - On wrap, scan index <= (index+1) mod NUM_DIGITS.
- Outputs are registered, updated one cycle after the index change:
  - vld[index]=1: anode = ~(1<<index), sevenSeg = hex encoding of dig[index], dp off (bit7=1).
  - vld[index]=0: anode all 1, sevenSeg=8'hFF (digit blanked, time slot kept).
- Hex encoding, active-low, 0..F: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E.
- Capture and scan are independent. A capture during a lit slot shows the new value from the next cycle.

Decomposition:
- Package display_pkg:
  - hex-to-segment function/constant table
  - SEG_BLANK=8'hFF
  - ANODE_OFF convention
  - clog2 width helpers for counter/index/count widths
- Sub-module button_conditioner (synchroniser + debounce + rising-edge pulse, parameter DB_CYCLES), instantiated twice (enter, clear).
- Digit buffer and scan logic live in the parent.

Test Plan:
(sim params: NUM_DIGITS=4, DB_CYCLES=4, REFRESH_CYCLES=8)
1. Reset -> anode=4'hF, sevenSeg=8'hFF, dataLed=0, count=0. Release reset with no stimulus, run 100 cycles -> anode stays 4'hF.
2. enter pulsed high for 3 cycles, dataIn=5 -> no capture, count=0. Then enter held high for 10 cycles -> exactly one capture: count=1, dataLed=5, and in slot 0 anode=4'hE, sevenSeg=8'h92.
3. dir=0, enter 1,2,3 -> count=3. dig0=3 (B0), dig1=2 (A4), dig2=1 (F9). Slot 3 is blanked: anode=4'hF, sevenSeg=8'hFF.
4. dir=0, enter 1,2,3,4,5 -> count=4. Digits 0..3 = 5,4,3,2; value 1 is lost.
5. Buffer full, then clear and enter debounced edges aligned to the same cycle -> count=0, all slots blank, dataLed=0.
6. dir=1, enter A then B -> dig3=B (83), dig2=A (88), count=2. Slots 0 and 1 are blanked. Assert rst mid-scan -> outputs go to reset values asynchronously, without waiting for a clock edge.

Source files
------------

// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared constants and helpers for the digit entry display:
//   - SEG_BLANK      : active-low segment pattern with every segment off
//   - ANODE_ON/OFF   : active-low anode drive levels
//   - index_width()  : bits needed to hold 0..n-1 (never less than 1)
//   - count_width()  : bits needed to hold 0..n
//   - hex_to_seg()   : 4-bit value to active-low {dp,g,f,e,d,c,b,a}, dp off
// -----------------------------------------------------------------------------
package display_pkg;

   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic       ANODE_OFF = 1'b1;
   localparam logic       ANODE_ON  = 1'b0;

   // Width of a counter/index that ranges over 0..n-1; a 1-state counter still
   // needs one bit so the declarations stay legal.
   function automatic int index_width(input int n);
      int w;
      if (n <= 1) begin
         w = 1;
      end else begin
         w = $clog2(n);
      end
      return w;
   endfunction

   // Width of a value that ranges over 0..n inclusive.
   function automatic int count_width(input int n);
      return index_width(n + 1);
   endfunction

   // Active-low hex glyphs; bit 7 (dp) is always 1 so the decimal point is off.
   function automatic logic [7:0] hex_to_seg(input logic [3:0] v);
      logic [7:0] seg;
      case (v)
         4'h0:    seg = 8'hC0;
         4'h1:    seg = 8'hF9;
         4'h2:    seg = 8'hA4;
         4'h3:    seg = 8'hB0;
         4'h4:    seg = 8'h99;
         4'h5:    seg = 8'h92;
         4'h6:    seg = 8'h82;
         4'h7:    seg = 8'hF8;
         4'h8:    seg = 8'h80;
         4'h9:    seg = 8'h90;
         4'hA:    seg = 8'h88;
         4'hB:    seg = 8'h83;
         4'hC:    seg = 8'hC6;
         4'hD:    seg = 8'hA1;
         4'hE:    seg = 8'h86;
         4'hF:    seg = 8'h8E;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/digit_entry_display_button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
// Conditions one raw push button: 2-FF synchroniser, debounce counter and a
// one-cycle pulse on each debounced press (release produces nothing).
// The debounced level changes only after the synchronised input has differed
// from it for DB_CYCLES consecutive cycles.
// Ports:
//   clk_i    system clock
//   rst_ni   asynchronous active-low reset
//   btn_i    raw button, active-high, asynchronous to clk_i
//   pulse_o  one-cycle pulse, registered, on a debounced rising edge
// -----------------------------------------------------------------------------
module button_conditioner
   import display_pkg::*;
#(
   parameter int DB_CYCLES = 500000
)(
   input  logic clk_i,
   input  logic rst_ni,
   input  logic btn_i,
   output logic pulse_o
);

   localparam int               CNT_W    = index_width(DB_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             sync1_q;
   logic             sync2_q;
   logic             level_q;
   logic             level_d;
   logic             pulse_q;
   logic             pulse_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Debounce counter and level update; counter restarts whenever input agrees.
   always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      if (sync2_q == level_q) begin
         cnt_d = CNT_ZERO;
      end else if (cnt_q == CNT_LAST) begin
         // This is the DB_CYCLES-th consecutive differing cycle.
         level_d = ~level_q;
         cnt_d   = CNT_ZERO;
      end else begin
         cnt_d = cnt_q + CNT_ONE;
      end
      pulse_d = level_d & ~level_q;
   end

   // Synchroniser, debounce state and pulse registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= CNT_ZERO;
         pulse_q <= 1'b0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
         pulse_q <= pulse_d;
      end
   end

   assign pulse_o = pulse_q;

endmodule

// File: rtl/digit_entry_display.sv
// -----------------------------------------------------------------------------
// digit_entry_display
// Keypad-style entry display. Each debounced enter press shifts dataIn into an
// NUM_DIGITS-deep digit buffer (direction chosen by dir), clear empties it.
// The buffer is shown on a multiplexed active-low seven-segment display; slots
// holding no captured digit are blanked but keep their time slot.
// Ports:
//   clk       system clock
//   rst       asynchronous active-low reset
//   enter     raw button, captures dataIn
//   clear     raw button, empties the buffer (wins over a simultaneous enter)
//   dir       raw switch: 0 = new digit at index 0, 1 = at index NUM_DIGITS-1
//   dataIn    4-bit hex value to capture
//   sevenSeg  active-low segments {dp,g,f,e,d,c,b,a}
//   anode     active-low one-hot digit select
//   dataLed   last captured value
//   count     number of filled digits, saturating at NUM_DIGITS
// -----------------------------------------------------------------------------
module digit_entry_display
   import display_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int DB_CYCLES      = 500000,
   parameter int REFRESH_CYCLES = 100000
)(
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            enter,
   input  logic                            clear,
   input  logic                            dir,
   input  logic [3:0]                      dataIn,
   output logic [7:0]                      sevenSeg,
   output logic [NUM_DIGITS-1:0]           anode,
   output logic [3:0]                      dataLed,
   output logic [$clog2(NUM_DIGITS+1)-1:0] count
);

   localparam int IDX_W   = index_width(NUM_DIGITS);
   localparam int REF_W   = index_width(REFRESH_CYCLES);
   localparam int COUNT_W = count_width(NUM_DIGITS);

   localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
   localparam logic [IDX_W-1:0]      IDX_ZERO   = {IDX_W{1'b0}};
   localparam logic [IDX_W-1:0]      IDX_ONE    = IDX_W'(1);
   localparam logic [REF_W-1:0]      REF_LAST   = REF_W'(REFRESH_CYCLES - 1);
   localparam logic [REF_W-1:0]      REF_ZERO   = {REF_W{1'b0}};
   localparam logic [REF_W-1:0]      REF_ONE    = REF_W'(1);
   localparam logic [COUNT_W-1:0]    COUNT_FULL = COUNT_W'(NUM_DIGITS);
   localparam logic [COUNT_W-1:0]    COUNT_ZERO = {COUNT_W{1'b0}};
   localparam logic [COUNT_W-1:0]    COUNT_ONE  = COUNT_W'(1);
   localparam logic [NUM_DIGITS-1:0] ANODES_OFF = {NUM_DIGITS{ANODE_OFF}};
   localparam logic [NUM_DIGITS-1:0] VLD_NONE   = {NUM_DIGITS{1'b0}};

   logic                  enter_pulse_s;
   logic                  clear_pulse_s;
   logic                  dir_s1_q;
   logic                  dir_s2_q;

   logic [3:0]            dig_q [NUM_DIGITS];
   logic [3:0]            dig_d [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] vld_q;
   logic [NUM_DIGITS-1:0] vld_d;
   logic [COUNT_W-1:0]    count_q;
   logic [COUNT_W-1:0]    count_d;
   logic [3:0]            led_q;
   logic [3:0]            led_d;

   logic [REF_W-1:0]      ref_q;
   logic [REF_W-1:0]      ref_d;
   logic [IDX_W-1:0]      idx_q;
   logic [IDX_W-1:0]      idx_d;

   logic [NUM_DIGITS-1:0] anode_q;
   logic [NUM_DIGITS-1:0] anode_d;
   logic [7:0]            seg_q;
   logic [7:0]            seg_d;

   button_conditioner #(.DB_CYCLES(DB_CYCLES)) u_enter_cond (
      .clk_i   (clk),
      .rst_ni  (rst),
      .btn_i   (enter),
      .pulse_o (enter_pulse_s)
   );

   button_conditioner #(.DB_CYCLES(DB_CYCLES)) u_clear_cond (
      .clk_i   (clk),
      .rst_ni  (rst),
      .btn_i   (clear),
      .pulse_o (clear_pulse_s)
   );

   // Digit buffer next state: clear has priority, enter shifts in dataIn.
   always_comb begin
      dig_d   = dig_q;
      vld_d   = vld_q;
      count_d = count_q;
      led_d   = led_q;
      if (clear_pulse_s) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            dig_d[i] = 4'h0;
         end
         vld_d   = VLD_NONE;
         count_d = COUNT_ZERO;
         led_d   = 4'h0;
      end else if (enter_pulse_s) begin
         // The valid pattern shifts along with the digits, so a direction
         // change on a partly filled buffer is not re-aligned.
         if (dir_s2_q) begin
            for (int i = 0; i < NUM_DIGITS - 1; i++) begin
               dig_d[i] = dig_q[i+1];
               vld_d[i] = vld_q[i+1];
            end
            dig_d[NUM_DIGITS-1] = dataIn;
            vld_d[NUM_DIGITS-1] = 1'b1;
         end else begin
            for (int i = 1; i < NUM_DIGITS; i++) begin
               dig_d[i] = dig_q[i-1];
               vld_d[i] = vld_q[i-1];
            end
            dig_d[0] = dataIn;
            vld_d[0] = 1'b1;
         end
         led_d = dataIn;
         if (count_q == COUNT_FULL) begin
            count_d = count_q;
         end else begin
            count_d = count_q + COUNT_ONE;
         end
      end else begin
         count_d = count_q;
      end
   end

   // Refresh timer and scan index; index advances on each timer wrap.
   always_comb begin
      ref_d = ref_q;
      idx_d = idx_q;
      if (ref_q == REF_LAST) begin
         ref_d = REF_ZERO;
         if (idx_q == IDX_LAST) begin
            idx_d = IDX_ZERO;
         end else begin
            idx_d = idx_q + IDX_ONE;
         end
      end else begin
         ref_d = ref_q + REF_ONE;
      end
   end

   // Display drive for the current slot; unfilled slots stay dark.
   always_comb begin
      anode_d = ANODES_OFF;
      seg_d   = SEG_BLANK;
      if (vld_q[idx_q]) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            anode_d[i] = (IDX_W'(i) == idx_q) ? ANODE_ON : ANODE_OFF;
         end
         seg_d = hex_to_seg(dig_q[idx_q]);
      end else begin
         anode_d = ANODES_OFF;
      end
   end

   // All state and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dir_s1_q <= 1'b0;
         dir_s2_q <= 1'b0;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            dig_q[i] <= 4'h0;
         end
         vld_q    <= VLD_NONE;
         count_q  <= COUNT_ZERO;
         led_q    <= 4'h0;
         ref_q    <= REF_ZERO;
         idx_q    <= IDX_ZERO;
         anode_q  <= ANODES_OFF;
         seg_q    <= SEG_BLANK;
      end else begin
         dir_s1_q <= dir;
         dir_s2_q <= dir_s1_q;
         dig_q    <= dig_d;
         vld_q    <= vld_d;
         count_q  <= count_d;
         led_q    <= led_d;
         ref_q    <= ref_d;
         idx_q    <= idx_d;
         anode_q  <= anode_d;
         seg_q    <= seg_d;
      end
   end

   assign sevenSeg = seg_q;
   assign anode    = anode_q;
   assign dataLed  = led_q;
   assign count    = count_q;

endmodule

// File: tb/tb_digit_entry_display.sv
module tb_digit_entry_display;

   localparam int ND = 4;
   localparam int DB = 4;
   localparam int RF = 8;

   logic       clk    = 1'b0;
   logic       rst    = 1'b1;
   logic       enter  = 1'b0;
   logic       clear  = 1'b0;
   logic       dir    = 1'b0;
   logic [3:0] dataIn = 4'h0;
   logic [7:0] sevenSeg;
   logic [3:0] anode;
   logic [3:0] dataLed;
   logic [2:0] count;

   int total = 0;
   int bad   = 0;
   int cyc;

   digit_entry_display #(
      .NUM_DIGITS     (ND),
      .DB_CYCLES      (DB),
      .REFRESH_CYCLES (RF)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .enter    (enter),
      .clear    (clear),
      .dir      (dir),
      .dataIn   (dataIn),
      .sevenSeg (sevenSeg),
      .anode    (anode),
      .dataLed  (dataLed),
      .count    (count)
   );

   always #5 clk = ~clk;

   // Edges since reset release; output slot after edge n is ((n-1)/RF)%ND.
   always @(posedge clk or negedge rst) begin
      if (!rst) cyc <= 0;
      else      cyc <= cyc + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        ent;
      logic        clr;
      logic        dr;
      logic [3:0]  data;
      logic [2:0]  ecnt;
      logic [3:0]  eled;
      logic        slots;
      logic [15:0] ean;   // {slot3,slot2,slot1,slot0}
      logic [31:0] eseg;  // {slot3,slot2,slot1,slot0}
   } vec_t;

   vec_t vt [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_slot(input int k, input logic [3:0] ean, input logic [7:0] eseg);
      bit found;
      found = 1'b0;
      for (int n = 0; n < 64 && !found; n++) begin
         @(negedge clk);
         if (cyc >= 1 && (((cyc - 1) / RF) % ND) == k) begin
            found = 1'b1;
            chk($sformatf("slot%0d anode", k), {28'h0, anode}, {28'h0, ean});
            chk($sformatf("slot%0d seg", k), {24'h0, sevenSeg}, {24'h0, eseg});
         end
      end
      if (!found) begin
         total++;
         bad++;
         $display("FAIL slot%0d wait: slot never reached, expected within 64 cycles", k);
      end
   endtask

   task automatic press(input logic e, input logic c, input logic d, input logic [3:0] v);
      @(negedge clk);
      dir    = d;
      dataIn = v;
      enter  = e;
      clear  = c;
      repeat (10) @(negedge clk);
      enter = 1'b0;
      clear = 1'b0;
      repeat (12) @(negedge clk);
   endtask

   initial begin
      int lit;
      vt[0] = '{1'b1, 1'b0, 1'b0, 4'h5, 3'd1, 4'h5, 1'b1, 16'hFFFE, 32'hFFFFFF92};
      vt[1] = '{1'b0, 1'b1, 1'b0, 4'h0, 3'd0, 4'h0, 1'b1, 16'hFFFF, 32'hFFFFFFFF};
      vt[2] = '{1'b1, 1'b0, 1'b0, 4'h1, 3'd1, 4'h1, 1'b0, 16'h0000, 32'h00000000};
      vt[3] = '{1'b1, 1'b0, 1'b0, 4'h2, 3'd2, 4'h2, 1'b0, 16'h0000, 32'h00000000};
      vt[4] = '{1'b1, 1'b0, 1'b0, 4'h3, 3'd3, 4'h3, 1'b1, 16'hFBDE, 32'hFFF9A4B0};
      vt[5] = '{1'b1, 1'b0, 1'b0, 4'h4, 3'd4, 4'h4, 1'b0, 16'h0000, 32'h00000000};
      vt[6] = '{1'b1, 1'b0, 1'b0, 4'h5, 3'd4, 4'h5, 1'b1, 16'h7BDE, 32'hA4B09992};
      vt[7] = '{1'b1, 1'b1, 1'b0, 4'h7, 3'd0, 4'h0, 1'b1, 16'hFFFF, 32'hFFFFFFFF};
      vt[8] = '{1'b1, 1'b0, 1'b1, 4'hA, 3'd1, 4'hA, 1'b0, 16'h0000, 32'h00000000};
      vt[9] = '{1'b1, 1'b0, 1'b1, 4'hB, 3'd2, 4'hB, 1'b1, 16'h7BFF, 32'h8388FFFF};

      // Reset values while held in reset.
      #2 rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset anode", {28'h0, anode}, 32'hF);
      chk("reset seg", {24'h0, sevenSeg}, 32'hFF);
      chk("reset led", {28'h0, dataLed}, 32'h0);
      chk("reset count", {29'h0, count}, 32'h0);

      // Idle after release: nothing lights.
      rst = 1'b1;
      lit = 0;
      repeat (100) begin
         @(negedge clk);
         if (anode !== 4'hF) lit++;
      end
      chk("idle lit cycles", lit, 0);

      // Short glitch on enter is filtered out.
      @(negedge clk);
      dataIn = 4'h5;
      enter  = 1'b1;
      repeat (3) @(negedge clk);
      enter = 1'b0;
      repeat (12) @(negedge clk);
      chk("glitch count", {29'h0, count}, 32'h0);
      chk("glitch led", {28'h0, dataLed}, 32'h0);

      // Table-driven press sequence.
      for (int i = 0; i < 10; i++) begin
         press(vt[i].ent, vt[i].clr, vt[i].dr, vt[i].data);
         chk($sformatf("vec%0d count", i), {29'h0, count}, {29'h0, vt[i].ecnt});
         chk($sformatf("vec%0d led", i), {28'h0, dataLed}, {28'h0, vt[i].eled});
         if (vt[i].slots) begin
            for (int k = 0; k < ND; k++) begin
               check_slot(k, vt[i].ean[k*4 +: 4], vt[i].eseg[k*8 +: 8]);
            end
         end
      end

      // Asynchronous reset while slot 3 is lit: outputs clear before any edge.
      check_slot(3, 4'h7, 8'h83);
      #1 rst = 1'b0;
      #1;
      chk("async rst anode", {28'h0, anode}, 32'hF);
      chk("async rst seg", {24'h0, sevenSeg}, 32'hFF);
      chk("async rst count", {29'h0, count}, 32'h0);
      chk("async rst led", {28'h0, dataLed}, 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      lit = 0;
      repeat (40) begin
         @(negedge clk);
         if (anode !== 4'hF) lit++;
      end
      chk("post rst lit cycles", lit, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
